// File: rtl/fifo_write_dispatcher_pkg.sv
// Shared types and constants for the AXI write-side FIFO dispatcher.
// Decode bit defaults are common with the read-side decoder.
package fifo_write_dispatcher_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef enum logic {
        RESP_OKAY   = 1'b0,
        RESP_SLVERR = 1'b1
    } resp_e;

    localparam int DEF_SPACE_BIT   = 17;
    localparam int DEF_REG_SEL_BIT = 8;

endpackage

// File: rtl/fifo_write_dispatcher_decode.sv
// Address decode into register file, descriptor memory or drop.
// Purely combinational; shared with the read path.
module fifo_dispatch_decode
    import fifo_write_dispatcher_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int SPACE_BIT   = DEF_SPACE_BIT,
    parameter int REG_SEL_BIT = DEF_REG_SEL_BIT
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit_reg,
    output logic              hit_mem,
    output logic              drop
);

    logic unused_addr;

    assign hit_reg = addr[SPACE_BIT] & addr[REG_SEL_BIT];
    assign hit_mem = addr[SPACE_BIT] & ~addr[REG_SEL_BIT];
    assign drop    = ~addr[SPACE_BIT];

    // only two address bits take part in the decode
    assign unused_addr = ^addr;

endmodule

// File: rtl/fifo_write_dispatcher.sv
// Drains AXI write address/data FIFOs, routes each write to its target
// and returns a write response once the target accepts it.
module fifo_write_dispatcher
    import fifo_write_dispatcher_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int SPACE_BIT   = DEF_SPACE_BIT,
    parameter int REG_SEL_BIT = DEF_REG_SEL_BIT,
    parameter int CNT_W       = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] addr_fifo_i,
    input  logic              addr_empty_i,
    input  logic [DATA_W-1:0] data_fifo_i,
    input  logic [STRB_W-1:0] strb_fifo_i,
    input  logic              data_empty_i,
    output logic              addr_rd_en_o,
    output logic              data_rd_en_o,
    output logic              reg_wr_en_o,
    input  logic              reg_ready_i,
    output logic              mem_wr_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [STRB_W-1:0] wr_strb_o,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic              busy_o
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [STRB_W-1:0] hold_strb;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              hit_reg;
    logic              hit_mem;
    logic              drop;
    logic              accept;
    logic              heads_ok;
    logic              pop;
    logic              done;
    resp_e             resp;

    fifo_dispatch_decode #(
        .ADDR_W      (ADDR_W),
        .SPACE_BIT   (SPACE_BIT),
        .REG_SEL_BIT (REG_SEL_BIT)
    ) u_decode (
        .addr    (hold_addr),
        .hit_reg (hit_reg),
        .hit_mem (hit_mem),
        .drop    (drop)
    );

    always_comb begin
        accept = 1'b1;
        unique case (1'b1)
            hit_reg: accept = reg_ready_i;
            hit_mem: accept = mem_ready_i;
            default: accept = 1'b1;
        endcase
    end

    // both FIFOs must present a head; reset also blocks pops
    assign heads_ok = Rst & enable_i & ~addr_empty_i & ~data_empty_i;
    assign done     = (state_q == ISSUE) & accept;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        reg_wr_en_o  = 1'b0;
        mem_wr_o     = 1'b0;
        wr_addr_o    = '0;
        wr_data_o    = '0;
        wr_strb_o    = '0;
        resp_valid_o = 1'b0;
        resp         = RESP_OKAY;
        unique case (state_q)
            IDLE: begin
                pop = heads_ok;
                if (pop) state_d = ISSUE;
            end
            ISSUE: begin
                reg_wr_en_o  = hit_reg;
                mem_wr_o     = hit_mem;
                if (!drop) begin
                    wr_addr_o = hold_addr;
                    wr_data_o = hold_data;
                    wr_strb_o = hold_strb;
                end
                resp_valid_o = accept;
                if (accept && drop) resp = RESP_SLVERR;
                pop = heads_ok & accept;
                if (accept && !pop) state_d = IDLE;
            end
        endcase
    end

    assign addr_rd_en_o = pop;
    assign data_rd_en_o = pop;
    assign resp_err_o   = resp;
    assign drop_cnt_o   = drop_cnt_q;
    assign busy_o       = (state_q == ISSUE);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            hold_addr  <= '0;
            hold_data  <= '0;
            hold_strb  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                hold_addr <= addr_fifo_i;
                hold_data <= data_fifo_i;
                hold_strb <= strb_fifo_i;
            end else if (done) begin
                hold_addr <= '0;
                hold_data <= '0;
                hold_strb <= '0;
            end
            if (done && drop && drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_dispatcher.sv
// Self-checking bench: queue-based FIFOs and a transaction-level model
// of the dispatcher, directed scenarios followed by random traffic.
module tb_fifo_write_dispatcher;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
    } dent_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        enable_i = 1'b0;
    logic [31:0] addr_fifo_i = '0;
    logic        addr_empty_i = 1'b1;
    logic [31:0] data_fifo_i = '0;
    logic [3:0]  strb_fifo_i = '0;
    logic        data_empty_i = 1'b1;
    logic        addr_rd_en_o;
    logic        data_rd_en_o;
    logic        reg_wr_en_o;
    logic        reg_ready_i = 1'b0;
    logic        mem_wr_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_strb_o;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic [7:0]  drop_cnt_o;
    logic        busy_o;

    fifo_write_dispatcher dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .enable_i     (enable_i),
        .addr_fifo_i  (addr_fifo_i),
        .addr_empty_i (addr_empty_i),
        .data_fifo_i  (data_fifo_i),
        .strb_fifo_i  (strb_fifo_i),
        .data_empty_i (data_empty_i),
        .addr_rd_en_o (addr_rd_en_o),
        .data_rd_en_o (data_rd_en_o),
        .reg_wr_en_o  (reg_wr_en_o),
        .reg_ready_i  (reg_ready_i),
        .mem_wr_o     (mem_wr_o),
        .mem_ready_i  (mem_ready_i),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .wr_strb_o    (wr_strb_o),
        .resp_valid_o (resp_valid_o),
        .resp_err_o   (resp_err_o),
        .drop_cnt_o   (drop_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 Clk = ~Clk;

    logic [31:0] aq[$];
    dent_t       dq[$];

    bit          m_held;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    int          m_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int d_resp  = 0;
    int d_pop   = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        addr_empty_i = (aq.size() == 0);
        data_empty_i = (dq.size() == 0);
        addr_fifo_i  = addr_empty_i ? $urandom : aq[0];
        if (data_empty_i) begin
            data_fifo_i = $urandom;
            strb_fifo_i = 4'($urandom);
        end else begin
            data_fifo_i = dq[0].d;
            strb_fifo_i = dq[0].s;
        end
    endtask

    function automatic logic [31:0] mk_addr(input int cls);
        logic [31:0] a;
        a = $urandom;
        case (cls)
            0: a[17] = 1'b0;
            1: begin a[17] = 1'b1; a[8] = 1'b1; end
            default: begin a[17] = 1'b1; a[8] = 1'b0; end
        endcase
        return a;
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        aq.push_back(a);
        dq.push_back('{d: d, s: s});
    endtask

    // target: 0 drop, 1 register file, 2 descriptor memory
    task automatic step();
        int          tgt;
        bit          acc;
        bit          pop;
        bit          mapped;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        drive();
        #1;
        tgt    = (m_addr[17] == 1'b0) ? 0 : (m_addr[8] ? 1 : 2);
        acc    = (tgt == 1) ? reg_ready_i : (tgt == 2) ? mem_ready_i : 1'b1;
        pop    = Rst && enable_i && aq.size() > 0 && dq.size() > 0
                 && (!m_held || acc);
        mapped = m_held && tgt != 0;
        ea     = mapped ? m_addr : 32'd0;
        ed     = mapped ? m_data : 32'd0;
        es     = mapped ? m_strb : 4'd0;
        check("addr_rd_en", 64'(addr_rd_en_o), 64'(pop));
        check("data_rd_en", 64'(data_rd_en_o), 64'(pop));
        check("reg_wr_en", 64'(reg_wr_en_o), 64'(m_held && tgt == 1));
        check("mem_wr", 64'(mem_wr_o), 64'(m_held && tgt == 2));
        check("wr_addr", 64'(wr_addr_o), 64'(ea));
        check("wr_data", 64'(wr_data_o), 64'(ed));
        check("wr_strb", 64'(wr_strb_o), 64'(es));
        check("resp_valid", 64'(resp_valid_o), 64'(m_held && acc));
        check("resp_err", 64'(resp_err_o), 64'(m_held && acc && tgt == 0));
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_cnt));
        check("busy", 64'(busy_o), 64'(m_held));
        if (resp_valid_o) d_resp++;
        if (addr_rd_en_o) d_pop++;
        @(posedge Clk);
        if (m_held && acc && tgt == 0 && m_cnt < 255) m_cnt++;
        if (pop) begin
            m_held = 1'b1;
            m_addr = aq.pop_front();
            {m_data, m_strb} = dq.pop_front();
        end else if (m_held && acc) begin
            m_held = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!m_held && aq.size() == 0 && dq.size() == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 64'(addr_rd_en_o | data_rd_en_o), 64'd0);
        check({tag, "_wr"}, 64'(reg_wr_en_o | mem_wr_o), 64'd0);
        check({tag, "_wr_bus"}, {wr_addr_o, wr_data_o}, 64'd0);
        check({tag, "_strb"}, 64'(wr_strb_o), 64'd0);
        check({tag, "_resp"}, 64'(resp_valid_o | resp_err_o), 64'd0);
        check({tag, "_cnt"}, 64'(drop_cnt_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int r;
        int p;
        m_held = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_strb = '0;
        m_cnt  = 0;

        // reset with traffic already waiting
        enable_i = 1'b1;
        push(32'h0002_0104, 32'hDEAD_BEEF, 4'hF);
        drive();
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Rst = 1'b1;

        // 1: single register write
        reg_ready_i = 1'b1;
        step();
        check("t1_reg_wr_en", 64'(reg_wr_en_o), 64'd1);
        check("t1_addr", 64'(wr_addr_o), 64'h0002_0104);
        check("t1_data", 64'(wr_data_o), 64'hDEAD_BEEF);
        check("t1_resp", 64'({resp_valid_o, resp_err_o}), 64'b10);
        step();
        check("t1_idle", 64'(busy_o), 64'd0);
        drain();

        // 2: descriptor write stalled by the memory for 3 cycles
        reg_ready_i = 1'b0;
        mem_ready_i = 1'b0;
        push(32'h0002_0004, 32'h1234_5678, 4'h3);
        push(32'h0002_0100, 32'hCAFE_F00D, 4'hC);
        step();
        r = d_resp;
        p = d_pop;
        repeat (3) begin
            step();
            check("t2_hold_addr", 64'(wr_addr_o), 64'h0002_0004);
        end
        check("t2_no_resp", 64'(d_resp - r), 64'd0);
        check("t2_no_pop", 64'(d_pop - p), 64'd0);
        mem_ready_i = 1'b1;
        step();
        check("t2_one_resp", 64'(d_resp - r), 64'd1);
        reg_ready_i = 1'b1;
        drain();

        // 3: unmapped write, then saturation of the drop counter
        push(32'h0000_0100, 32'h5555_AAAA, 4'h1);
        step();
        check("t3_resp", 64'({resp_valid_o, resp_err_o}), 64'b11);
        check("t3_no_wr", 64'(reg_wr_en_o | mem_wr_o), 64'd0);
        check("t3_cnt0", 64'(drop_cnt_o), 64'd0);
        step();
        check("t3_cnt1", 64'(drop_cnt_o), 64'd1);
        for (int i = 0; i < 300; i++) push(mk_addr(0), $urandom, 4'($urandom));
        drain();
        check("t3_sat", 64'(drop_cnt_o), 64'd255);

        // 4: four back-to-back writes
        for (int i = 0; i < 4; i++) push(mk_addr(i % 3), $urandom, 4'($urandom));
        r = d_resp;
        p = d_pop;
        repeat (5) step();
        check("t4_resps", 64'(d_resp - r), 64'd4);
        check("t4_pops", 64'(d_pop - p), 64'd4);
        drain();

        // 5: address present, data missing
        aq.push_back(32'h0002_0108);
        repeat (5) begin
            step();
            check("t5_busy", 64'(busy_o), 64'd0);
        end
        dq.push_back('{d: 32'h0BAD_F00D, s: 4'h5});
        r = d_resp;
        drain();
        check("t5_resp", 64'(d_resp - r), 64'd1);

        // 6: reset while a register write is stalled
        reg_ready_i = 1'b0;
        push(32'h0002_0110, 32'h1111_2222, 4'hF);
        push(32'h0002_0120, 32'h3333_4444, 4'hA);
        step();
        step();
        r = d_resp;
        Rst = 1'b0;
        #1;
        check_all_zero("t6_rst");
        m_held = 1'b0;
        m_cnt  = 0;
        step();
        Rst = 1'b1;
        reg_ready_i = 1'b1;
        drain();
        check("t6_resp", 64'(d_resp - r), 64'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && aq.size() < 6)
                aq.push_back(mk_addr($urandom_range(0, 2)));
            if ($urandom_range(0, 2) == 0 && dq.size() < 6)
                dq.push_back('{d: $urandom, s: 4'($urandom)});
            enable_i    = ($urandom_range(0, 7) != 0);
            reg_ready_i = 1'($urandom);
            mem_ready_i = 1'($urandom);
            step();
        end
        while (aq.size() < dq.size()) aq.push_back(mk_addr($urandom_range(0, 2)));
        while (dq.size() < aq.size()) dq.push_back('{d: $urandom, s: 4'($urandom)});
        enable_i    = 1'b1;
        reg_ready_i = 1'b1;
        mem_ready_i = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_dispatcher.md
Name: fifo_write_dispatcher

Overview:
Parametrised successor of the AXI-side FIFO drain/interface block in the USB 2.0 host controller.
- Pops write address and write data (with byte strobes) from independent AXI write FIFOs.
- Decodes each transaction to the operational register file, descriptor memory or an unmapped drop path.
- Holds each write until the target accepts it, then returns a write response to the AXI slave.
- Adds over the previous generation: width and decode-bit parameters, separate empty flags, target backpressure, strobes, error response, drop counter and enable gating.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; multiple of 8
STRB_W, DATA_W/8, byte-strobe width
SPACE_BIT, 17, address bit that must be 1 for a mapped host-controller space
REG_SEL_BIT, 8, within mapped space: 1 = register file, 0 = descriptor memory
CNT_W, 8, width of the saturating drop counter

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-low reset
enable_i  in  1  1 = new pops allowed
addr_fifo_i  in  ADDR_W  head of address FIFO (first-word fall-through)
addr_empty_i  in  1  address FIFO empty
data_fifo_i  in  DATA_W  head of data FIFO
strb_fifo_i  in  STRB_W  head strobes, same FIFO entry as data
data_empty_i  in  1  data FIFO empty
addr_rd_en_o  out  1  pop address FIFO
data_rd_en_o  out  1  pop data FIFO
reg_wr_en_o  out  1  register-file write request
reg_ready_i  in  1  register file accepts
mem_wr_o  out  1  descriptor-memory write request
mem_ready_i  in  1  memory accepts
wr_addr_o  out  ADDR_W  held address; 0 when no request
wr_data_o  out  DATA_W  held data; 0 when no request
wr_strb_o  out  STRB_W  held strobes; 0 when no request
resp_valid_o  out  1  one-cycle write-response pulse
resp_err_o  out  1  1 = SLVERR (dropped); valid only with resp_valid_o
drop_cnt_o  out  CNT_W  saturating count of dropped writes
busy_o  out  1  transaction held (state ISSUE)

Behaviour:
- Reset:
  - State IDLE; holding registers, drop_cnt_o and every output 0.
  - An in-flight write is discarded with no response.
- States:
  - IDLE: nothing held.
  - ISSUE: one transaction held in hold_addr, hold_data and hold_strb.
- Decode (combinational on hold_addr):
  - hit_reg = hold_addr[SPACE_BIT] & hold_addr[REG_SEL_BIT]
  - hit_mem = hold_addr[SPACE_BIT] & ~hold_addr[REG_SEL_BIT]
  - drop = ~hold_addr[SPACE_BIT]
- accept = hit_reg ? reg_ready_i : hit_mem ? mem_ready_i : 1.
- pop = enable_i & ~addr_empty_i & ~data_empty_i & (state==IDLE | (state==ISSUE & accept)).
  - addr_rd_en_o and data_rd_en_o both equal pop, combinationally.
  - Never pop one FIFO without the other.
  - On pop, capture the FIFO heads into the hold registers at the clock edge.
- IDLE: pop -> ISSUE; otherwise stay.
- ISSUE outputs:
  - reg_wr_en_o = hit_reg; mem_wr_o = hit_mem.
  - wr_* = hold registers while hit_reg | hit_mem; 0 on drop.
  - Outputs are held stable until accept.
- ISSUE on accept:
  - resp_valid_o = 1 in the same cycle; resp_err_o = drop.
  - drop increments drop_cnt_o, saturating at all-ones.
  - pop -> reload and stay in ISSUE (back-to-back, 1 write/cycle); no pop -> IDLE.
- Latency: pop in cycle N -> write request visible in cycle N+1; response in the accept cycle.
- enable_i low:
  - A held transaction still completes.
  - No new pops; the block then idles.
- Only one FIFO non-empty: no pop, and the block waits.
- Ready deasserted: the request and wr_* stay asserted and unchanged indefinitely.
- A ready input for the non-selected target is ignored.
- Drop is never held more than 1 cycle.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, ISSUE=1);
  - response codes (OKAY=0, SLVERR=1);
  - default SPACE_BIT and REG_SEL_BIT constants shared with the read-side decoder.
- One natural sub-module, fifo_dispatch_decode: combinational hit_reg/hit_mem/drop from an address, reused by the read path.

Test Plan:
1. Addr 0x0002_0104, data 0xDEAD_BEEF, strb 0xF, reg_ready_i=1 -> pop at N; reg_wr_en_o=1 at N+1 with wr_addr_o=0x0002_0104 and wr_data_o=0xDEAD_BEEF; resp_valid_o=1, resp_err_o=0; return to IDLE.
2. Addr 0x0002_0004, mem_ready_i low for 3 cycles -> mem_wr_o and wr_* held stable for 4 cycles; exactly one resp_valid_o pulse on the ready cycle; no extra pop before it.
3. Addr 0x0000_0100 -> no write strobe; resp_valid_o=1 with resp_err_o=1 at N+1; drop_cnt_o 0->1. Repeat 300 drops -> drop_cnt_o saturates at 255.
4. Four writes queued, ready tied 1 -> four consecutive responses on consecutive cycles; pops on 4 consecutive cycles.
5. Address FIFO non-empty, data FIFO empty for 5 cycles -> no rd_en asserted and busy_o=0; the write proceeds once data arrives.
6. Rst asserted while ISSUE is stalled on reg_ready_i=0 -> all outputs 0 immediately, drop_cnt_o=0, no response; after release the next queued entry is processed normally.
